// File: rtl/fb_port_arbiter_if.sv
// Bus bundle for fb_port_arbiter: UART write strobe, display fetch, RAM port and status.
// ovf_cnt exists only when FBARB_OVF_CNT_EN is defined.
interface fb_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              wr_valid;
  logic [7:0]        wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              load_restart;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic              frame_loaded;
  logic              ovf;
`ifdef FBARB_OVF_CNT_EN
  logic [7:0]        ovf_cnt;
`endif

  modport slave (
    input  wr_valid, wr_data, rd_req, rd_addr, load_restart, ram_rdata,
    output rd_data, rd_valid, ram_addr, ram_we, ram_wdata, frame_loaded, ovf
`ifdef FBARB_OVF_CNT_EN
    , output ovf_cnt
`endif
  );

  modport master (
    output wr_valid, wr_data, rd_req, rd_addr, load_restart, ram_rdata,
    input  rd_data, rd_valid, ram_addr, ram_we, ram_wdata, frame_loaded, ovf
`ifdef FBARB_OVF_CNT_EN
    , input ovf_cnt
`endif
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Framebuffer single-port RAM arbiter: display reads win, UART bytes queue in a small FIFO.
// Optional dropped-byte counter output ovf_cnt enabled by macro FBARB_OVF_CNT_EN.
module fb_port_arbiter #(
  parameter int unsigned FB_BYTES   = 38462,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  fb_port_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_BYTES - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic              frame_loaded_q, frame_loaded_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        fifo_q [FIFO_DEPTH];

  logic              in_load_c, empty_c, full_c;
  logic              wr_gnt_c, push_c, drop_c;
  logic [ADDR_W-1:0] ram_addr_c;

  // Grant and FIFO handshake decode; restart blocks both the pop and the push.
  always_comb begin
    in_load_c = (state_q == ST_LOAD);
    empty_c   = (cnt_q == '0);
    full_c    = (cnt_q == CNT_FULL);
    wr_gnt_c  = !bus.rd_req && !empty_c && in_load_c && !bus.load_restart;
    push_c    = bus.wr_valid && in_load_c && !bus.load_restart && (!full_c || wr_gnt_c);
    drop_c    = bus.wr_valid && in_load_c && !bus.load_restart && full_c && !wr_gnt_c;
    if (!rst_n)           ram_addr_c = '0;
    else if (bus.rd_req)  ram_addr_c = bus.rd_addr;
    else if (wr_gnt_c)    ram_addr_c = wr_addr_q;
    else                  ram_addr_c = last_addr_q;
  end

  assign bus.ram_addr     = ram_addr_c;
  assign bus.ram_we       = rst_n && wr_gnt_c;
  assign bus.ram_wdata    = fifo_q[rd_ptr_q];
  assign bus.rd_data      = bus.ram_rdata;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.frame_loaded = frame_loaded_q;
  assign bus.ovf          = ovf_q;

  always_comb begin
    state_d        = state_q;
    wr_addr_d      = wr_addr_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    cnt_d          = cnt_q + CNT_W'(push_c) - CNT_W'(wr_gnt_c);
    rd_valid_d     = bus.rd_req;
    frame_loaded_d = frame_loaded_q;
    ovf_d          = ovf_q || drop_c;
    if (push_c)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (wr_gnt_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // Last byte of the frame: stop loading and flush anything still queued.
    if (wr_gnt_c) begin
      if (wr_addr_q == LAST_ADDR) begin
        state_d        = ST_FULL;
        frame_loaded_d = 1'b1;
        rd_ptr_d       = '0;
        wr_ptr_d       = '0;
        cnt_d          = '0;
      end else begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
      end
    end
    if (bus.load_restart) begin
      state_d        = ST_LOAD;
      wr_addr_d      = '0;
      rd_ptr_d       = '0;
      wr_ptr_d       = '0;
      cnt_d          = '0;
      frame_loaded_d = 1'b0;
      ovf_d          = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_LOAD;
      wr_addr_q      <= '0;
      last_addr_q    <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      cnt_q          <= '0;
      rd_valid_q     <= 1'b0;
      frame_loaded_q <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_addr_q      <= wr_addr_d;
      last_addr_q    <= ram_addr_c;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      cnt_q          <= cnt_d;
      rd_valid_q     <= rd_valid_d;
      frame_loaded_q <= frame_loaded_d;
      ovf_q          <= ovf_d;
    end
  end

  // FIFO storage carries no reset; occupancy is owned by cnt_q.
  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wr_ptr_q] <= bus.wr_data;
  end

`ifdef FBARB_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop_c && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
    if (bus.load_restart)               ovf_cnt_d = 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_cnt_q <= 8'd0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign bus.ovf_cnt = ovf_cnt_q;
`endif
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: directed scenarios plus random traffic
// checked every cycle against a queue-based frame-loading model.
module tb_fb_port_arbiter;
  localparam int unsigned FB    = 16;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fb_port_arbiter_if #(.ADDR_W(AW)) bus ();

  fb_port_arbiter #(.FB_BYTES(FB), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous single-port RAM, one-cycle read latency.
  logic [7:0] tb_ram [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (bus.ram_we) tb_ram[bus.ram_addr[7:0]] <= bus.ram_wdata;
    bus.ram_rdata <= tb_ram[bus.ram_addr[7:0]];
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: pending bytes, next frame address, and status flags.
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  logic [7:0] q [$];
  int         m_addr   = 0;
  bit         m_loaded = 0;
  bit         m_ovf    = 0;
  int         m_cnt    = 0;
  bit         m_rdv    = 0;
  logic [7:0] exp_rd   = 8'h00;
  logic [15:0] m_last  = 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_addr = 0; m_loaded = 0; m_ovf = 0; m_cnt = 0; m_rdv = 0; m_last = 16'h0;
  endtask

  task automatic step(input logic wv, input logic [7:0] wd, input logic rr,
                      input logic [15:0] ra, input logic lr);
    bit wg, full_b, acc;
    logic [15:0] ea;
    bus.wr_valid = wv; bus.wr_data = wd; bus.rd_req = rr; bus.rd_addr = ra;
    bus.load_restart = lr;
    @(negedge clk);
    wg = !rr && (q.size() > 0) && !m_loaded && !lr;
    ea = rr ? ra : (wg ? 16'(m_addr) : m_last);
    chk("ram_we", bus.ram_we, wg);
    chk("ram_addr", bus.ram_addr, ea);
    if (wg) chk("ram_wdata", bus.ram_wdata, q[0]);
    chk("rd_valid", bus.rd_valid, m_rdv);
    if (m_rdv) chk("rd_data", bus.rd_data, exp_rd);
    chk("frame_loaded", bus.frame_loaded, m_loaded);
    chk("ovf", bus.ovf, m_ovf);
`ifdef FBARB_OVF_CNT_EN
    chk("ovf_cnt", bus.ovf_cnt, m_cnt);
`endif
    @(posedge clk);
    full_b = (q.size() == DEPTH);
    m_rdv  = rr;
    if (rr) exp_rd = ref_mem[ra[7:0]];
    m_last = ea;
    if (lr) begin
      q.delete(); m_addr = 0; m_loaded = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      acc = wv && !m_loaded && (!full_b || wg);
      if (wv && !m_loaded && !acc) begin
        m_ovf = 1;
        if (m_cnt < 255) m_cnt++;
      end
      if (acc) q.push_back(wd);
      if (wg) begin
        ref_mem[m_addr] = q.pop_front();
        if (m_addr == FB - 1) begin
          m_loaded = 1;
          q.delete();
        end else m_addr++;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 16'h0, 0);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_data = 8'h5A; bus.rd_req = 1'b1;
    bus.rd_addr = 16'h1234; bus.load_restart = 1'b0;
    #12;
    chk("rst_ram_we", bus.ram_we, 1'b0);
    chk("rst_ram_addr", bus.ram_addr, 16'h0);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_frame_loaded", bus.frame_loaded, 1'b0);
    chk("rst_ovf", bus.ovf, 1'b0);
    bus.wr_valid = 1'b0; bus.rd_req = 1'b0; bus.rd_addr = 16'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Whole frame, bytes spaced 10 cycles apart, no reads.
    for (int i = 0; i < FB; i++) begin
      step(1, 8'(i), 0, 16'h0, 0);
      idle(9);
    end
    chk("frame_done", bus.frame_loaded, 1'b1);
    chk("frame_ovf", bus.ovf, 1'b0);

    // Back-to-back readback of the frame.
    for (int i = 0; i < FB; i++) step(0, 8'h00, 1, 16'(i), 0);
    idle(1);

    // Strobes in FULL are discarded silently.
    for (int i = 0; i < 5; i++) begin
      step(1, 8'hE0 + 8'(i), 0, 16'h0, 0);
      idle(1);
    end

    // Read burst of 8 with three bytes arriving in cycles 1..3.
    step(0, 8'h00, 0, 16'h0, 1);
    for (int i = 0; i < 8; i++)
      step((i >= 1 && i <= 3), 8'h30 + 8'(i), 1, 16'(i), 0);
    idle(5);

    // Read burst of 10 with six bytes: four fit, two dropped.
    for (int i = 0; i < 10; i++)
      step((i < 6), 8'h40 + 8'(i), 1, 16'(i + 3), 0);
    idle(6);
    chk("burst_ovf", bus.ovf, 1'b1);

    // Restart with a pop pending and a coincident strobe.
    step(1, 8'h51, 1, 16'h2, 0);
    step(1, 8'h52, 1, 16'h3, 0);
    step(1, 8'h53, 0, 16'h0, 1);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom % 3) == 0, 8'($urandom), ($urandom % 2) == 0,
           16'($urandom % 32), ($urandom % 97) == 0);
    idle(8);

    // Asynchronous reset at wr_addr 7, then the next byte lands at 0.
    step(0, 8'h00, 0, 16'h0, 1);
    guard = 0;
    while (m_addr != 7 && guard < 60) begin
      step(1, 8'h70 + 8'(guard), 0, 16'h0, 0);
      guard++;
    end
    chk("reach_addr7", 32'(m_addr), 32'd7);
    bus.wr_valid = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = 16'h9;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ram_we", bus.ram_we, 1'b0);
    chk("arst_ram_addr", bus.ram_addr, 16'h0);
    chk("arst_rd_valid", bus.rd_valid, 1'b0);
    chk("arst_frame_loaded", bus.frame_loaded, 1'b0);
    chk("arst_ovf", bus.ovf, 1'b0);
    bus.wr_valid = 1'b0; bus.rd_req = 1'b0; bus.rd_addr = 16'h0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    step(1, 8'hA5, 0, 16'h0, 0);
    idle(3);
    chk("post_rst_byte", tb_ram[0], 8'hA5);

    // RAM image agrees with the model's picture of every frame address.
    for (int i = 0; i < FB; i++) chk("ram_image", tb_ram[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
